// File: rtl/gate_interlock.sv
// rtl/gate_interlock.sv - half-bridge gate interlock with dead time, desat blanking and fault latch
// Optional overlap-event counter enabled by defining GATE_OVL_CNT_EN.
module gate_interlock #(
    parameter int DEADTIME = 40,
    parameter int BLANK    = 80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       k1_in,
    input  logic       k2_in,
    input  logic       desat,
    input  logic       flt_clr,
    output logic       gh,
    output logic       gl,
    output logic       fault,
    output logic [7:0] ovl_cnt
);

    localparam int DTW = (DEADTIME < 1) ? 1 : $clog2(DEADTIME + 1);
    localparam int BW  = (BLANK < 1) ? 1 : $clog2(BLANK + 1);

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_H_ON  = 2'd1,
        S_L_ON  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [DTW-1:0]   dt_cnt_q, dt_cnt_d;
    logic [BW-1:0]    blank_cnt_q, blank_cnt_d;
    logic             desat_m_q, desat_m_d;
    logic             desat_s_q, desat_s_d;
    logic             gh_q, gh_d;
    logic             gl_q, gl_d;
    logic             fault_q, fault_d;
    logic             dt_done;
    logic             blank_done;

    assign dt_done    = (dt_cnt_q == DTW'(DEADTIME));
    assign blank_done = (blank_cnt_q == BW'(BLANK));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_OFF;
            dt_cnt_q    <= '0;
            blank_cnt_q <= '0;
            desat_m_q   <= 1'b0;
            desat_s_q   <= 1'b0;
            gh_q        <= 1'b0;
            gl_q        <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            dt_cnt_q    <= dt_cnt_d;
            blank_cnt_q <= blank_cnt_d;
            desat_m_q   <= desat_m_d;
            desat_s_q   <= desat_s_d;
            gh_q        <= gh_d;
            gl_q        <= gl_d;
            fault_q     <= fault_d;
        end
    end

    // Desat is only acted on once blanking has expired; fault wins over a normal exit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_OFF: begin
                if (dt_done && k1_in && !k2_in) begin
                    state_d = S_H_ON;
                end else if (dt_done && k2_in && !k1_in) begin
                    state_d = S_L_ON;
                end
            end
            S_H_ON: begin
                if (blank_done && desat_s_q) begin
                    state_d = S_FAULT;
                end else if (!k1_in || k2_in) begin
                    state_d = S_OFF;
                end
            end
            S_L_ON: begin
                if (!k2_in || k1_in) begin
                    state_d = S_OFF;
                end
            end
            default: begin
                if (flt_clr && !k1_in && !k2_in) begin
                    state_d = S_OFF;
                end
            end
        endcase
    end

    always_comb begin
        desat_m_d   = desat;
        desat_s_d   = desat_m_q;
        dt_cnt_d    = dt_cnt_q;
        blank_cnt_d = blank_cnt_q;
        if (state_d == S_OFF && state_q != S_OFF) begin
            dt_cnt_d = '0;
        end else if (state_q == S_OFF && !dt_done) begin
            dt_cnt_d = dt_cnt_q + DTW'(1);
        end
        if (state_d == S_H_ON && state_q != S_H_ON) begin
            blank_cnt_d = '0;
        end else if (state_q == S_H_ON && !blank_done) begin
            blank_cnt_d = blank_cnt_q + BW'(1);
        end
    end

    // Outputs are registered from the next state so they track the state register exactly.
    always_comb begin
        gh_d    = (state_d == S_H_ON);
        gl_d    = (state_d == S_L_ON);
        fault_d = (state_d == S_FAULT);
    end

    assign gh    = gh_q;
    assign gl    = gl_q;
    assign fault = fault_q;

`ifdef GATE_OVL_CNT_EN
    logic       ovl_prev_q, ovl_prev_d;
    logic [7:0] ovl_cnt_q, ovl_cnt_d;

    always_comb begin
        ovl_prev_d = k1_in & k2_in;
        ovl_cnt_d  = ovl_cnt_q;
        if (ovl_prev_d && !ovl_prev_q && ovl_cnt_q != 8'hFF) begin
            ovl_cnt_d = ovl_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovl_prev_q <= 1'b0;
            ovl_cnt_q  <= 8'd0;
        end else begin
            ovl_prev_q <= ovl_prev_d;
            ovl_cnt_q  <= ovl_cnt_d;
        end
    end

    assign ovl_cnt = ovl_cnt_q;
`else
    assign ovl_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_gate_interlock.sv
// tb/tb_gate_interlock.sv - self-checking bench for gate_interlock
module tb_gate_interlock;

    localparam int DT = 40;
    localparam int BL = 80;
`ifdef GATE_OVL_CNT_EN
    localparam int OVL_EN = 1;
`else
    localparam int OVL_EN = 0;
`endif

    localparam int M_IDLE = 0;
    localparam int M_HIGH = 1;
    localparam int M_LOW  = 2;
    localparam int M_FLT  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       k1_in = 1'b0;
    logic       k2_in = 1'b0;
    logic       desat = 1'b0;
    logic       flt_clr = 1'b0;
    logic       gh, gl, fault;
    logic [7:0] ovl_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int   m_mode = M_IDLE;
    int   m_off_since = 0;
    int   m_on_since = 0;
    int   m_ovl = 0;
    logic m_h1 = 1'b0, m_h2 = 1'b0, m_prev = 1'b0, m_valid = 1'b0;
    logic m_ds, m_both;

    logic ovl_window = 1'b0;
    int   ovl_gate_hits = 0;

    gate_interlock #(.DEADTIME(DT), .BLANK(BL)) dut (
        .clk     (clk),
        .rst     (rst),
        .k1_in   (k1_in),
        .k2_in   (k2_in),
        .desat   (desat),
        .flt_clr (flt_clr),
        .gh      (gh),
        .gl      (gl),
        .fault   (fault),
        .ovl_cnt (ovl_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    // Model: time-stamp view of the interlock rules, stepped on each rising edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            m_valid     = 1'b1;
            m_mode      = M_IDLE;
            m_off_since = cyc;
            m_h1        = 1'b0;
            m_h2        = 1'b0;
            m_prev      = 1'b0;
            m_ovl       = 0;
        end else if (m_valid) begin
            m_ds   = m_h2;
            m_h2   = m_h1;
            m_h1   = desat;
            m_both = k1_in & k2_in;
            if (OVL_EN != 0 && m_both && !m_prev && m_ovl < 255) m_ovl = m_ovl + 1;
            m_prev = m_both;
            case (m_mode)
                M_IDLE: begin
                    if (cyc - m_off_since > DT) begin
                        if (k1_in && !k2_in) begin
                            m_mode = M_HIGH;
                            m_on_since = cyc;
                        end else if (k2_in && !k1_in) begin
                            m_mode = M_LOW;
                        end
                    end
                end
                M_HIGH: begin
                    if (m_ds && (cyc - m_on_since > BL)) begin
                        m_mode = M_FLT;
                    end else if (!k1_in || k2_in) begin
                        m_mode = M_IDLE;
                        m_off_since = cyc;
                    end
                end
                M_LOW: begin
                    if (!k2_in || k1_in) begin
                        m_mode = M_IDLE;
                        m_off_since = cyc;
                    end
                end
                default: begin
                    if (flt_clr && !k1_in && !k2_in) begin
                        m_mode = M_IDLE;
                        m_off_since = cyc;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("gh", gh, (m_mode == M_HIGH) ? 1 : 0);
            check("gl", gl, (m_mode == M_LOW) ? 1 : 0);
            check("fault", fault, (m_mode == M_FLT) ? 1 : 0);
            check("ovl_cnt", ovl_cnt, m_ovl);
            check("excl", gh & gl, 0);
            if (ovl_window && (gh || gl)) ovl_gate_hits++;
        end
    end

    function automatic logic pick(input int w);
        case (w)
            0:       return gh;
            1:       return gl;
            default: return fault;
        endcase
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_sig(input int which, input logic val, input int budget,
                            input string name, output int edge_at);
        edge_at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (pick(which) === val) begin
                edge_at = cyc;
                break;
            end
        end
        if (edge_at < 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: actual=none required=%0d within %0d cycles", name, val, budget);
        end
    endtask

    int base, e, g, gl_fall;

    initial begin
        step(2);
        check("rst_gh", gh, 0);
        check("rst_gl", gl, 0);
        check("rst_fault", fault, 0);
        check("rst_ovl", ovl_cnt, 0);

        rst = 1'b0; k2_in = 1'b1; base = cyc;
        wait_sig(1, 1'b1, 60, "gl_rise", e);
        check("gl_rise_lat", e - base, 41);

        step(5);
        k2_in = 1'b0; k1_in = 1'b1; base = cyc;
        wait_sig(1, 1'b0, 5, "gl_fall", e);
        check("gl_fall_lat", e - base, 1);
        gl_fall = e;
        wait_sig(0, 1'b1, 60, "gh_rise", e);
        check("dead_time", e - gl_fall, 41);
        g = e;

        wait_cyc(g + 10);
        desat = 1'b1;
        step(3);
        desat = 1'b0;
        wait_cyc(g + 90);
        desat = 1'b1;
        wait_sig(2, 1'b1, 10, "fault_rise", e);
        check("desat_lat", e - g, 93);
        check("gh_in_fault", gh, 0);

        step(1);
        desat = 1'b0; k1_in = 1'b0; k2_in = 1'b1; flt_clr = 1'b1;
        step(3);
        check("flt_hold", fault, 1);
        k2_in = 1'b0; base = cyc;
        step(1);
        flt_clr = 1'b0; k1_in = 1'b1;
        wait_sig(2, 1'b0, 5, "fault_clr", e);
        check("clr_lat", e - base, 1);
        wait_sig(0, 1'b1, 60, "gh_after_clr", e);
        check("clr_dead", e - (base + 1), 41);

        step(3);
        k1_in = 1'b0;
        step(2);
        ovl_window = 1'b1;
        for (int r = 0; r < 3; r++) begin
            k1_in = 1'b1; k2_in = 1'b1;
            step(5);
            k1_in = 1'b0; k2_in = 1'b0;
            step(3);
        end
        check("ovl_cnt3", ovl_cnt, 3 * OVL_EN);
        repeat (260) begin
            k1_in = 1'b1; k2_in = 1'b1;
            step(1);
            k1_in = 1'b0; k2_in = 1'b0;
            step(1);
        end
        step(1);
        ovl_window = 1'b0;
        check("ovl_sat", ovl_cnt, 255 * OVL_EN);
        check("ovl_gates", ovl_gate_hits, 0);

        k1_in = 1'b1;
        wait_sig(0, 1'b1, 60, "gh_pre_rst", e);
        step(3);
        rst = 1'b1;
        step(1);
        check("rsth_gh", gh, 0);
        check("rsth_fault", fault, 0);
        check("rsth_ovl", ovl_cnt, 0);
        rst = 1'b0; k1_in = 1'b0; k2_in = 1'b1; base = cyc;
        wait_sig(1, 1'b1, 60, "gl_rise2", e);
        check("gl_rise2_lat", e - base, 41);

        k2_in = 1'b0; k1_in = 1'b1;
        wait_sig(0, 1'b1, 60, "gh_rise2", g);
        wait_cyc(g + BL + 2);
        desat = 1'b1;
        wait_sig(2, 1'b1, 10, "fault_rise2", e);
        rst = 1'b1; desat = 1'b0; k1_in = 1'b0;
        step(1);
        check("rstf_fault", fault, 0);
        check("rstf_gh", gh, 0);
        check("rstf_gl", gl, 0);
        rst = 1'b0; k2_in = 1'b1; base = cyc;
        wait_sig(1, 1'b1, 60, "gl_rise3", e);
        check("gl_rise3_lat", e - base, 41);

        step(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_interlock.md
GATE_INTERLOCK -- requirements
Module: gate_interlock

Interface
REQ-001 SHALL have parameter DEADTIME, default 40, minimum cycles both gates held low between any gate turn-off and the opposite turn-on (1 us at 40 MHz).
REQ-002 SHALL have parameter BLANK, default 80, cycles after gh turn-on during which desat is ignored (2 us).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port k1_in  input  1  high-side on command, from the double-pulse generator K1.
REQ-006 SHALL have port k2_in  input  1  low-side on command, from the double-pulse generator K2.
REQ-007 SHALL have port desat  input  1  asynchronous active-high desaturation flag from the high-side driver.
REQ-008 SHALL have port flt_clr  input  1  synchronous fault-clear request.
REQ-009 SHALL have port gh  output  1  registered high-side gate drive.
REQ-010 SHALL have port gl  output  1  registered low-side gate drive.
REQ-011 SHALL have port fault  output  1  registered latched-fault flag.
REQ-012 SHALL have port ovl_cnt  output  8  count of command-overlap events.

Function
REQ-013 SHALL pass desat through a 2-flop synchronizer (desat_s) before use; desat-to-action latency is therefore 3 cycles.
REQ-014 SHALL implement states OFF, H_ON, L_ON, FAULT: gh=1 only in H_ON, gl=1 only in L_ON, fault=1 only in FAULT.
REQ-015 OFF: dt_cnt increments each cycle, saturating at DEADTIME; dt_done = (dt_cnt == DEADTIME).
REQ-016 OFF -> H_ON when dt_done & k1_in & !k2_in; OFF -> L_ON when dt_done & k2_in & !k1_in; otherwise stay in OFF.
REQ-017 Command-to-gate latency SHALL be 1 cycle once dt_done is true.
REQ-018 H_ON -> OFF when !k1_in | k2_in, clearing dt_cnt to 0; L_ON -> OFF when !k2_in | k1_in, clearing dt_cnt to 0.
REQ-019 With the opposite command already present, the opposite gate SHALL rise exactly DEADTIME+1 cycles after the falling gate goes low.
REQ-020 H_ON: blank_cnt SHALL clear on entry and increment, saturating at BLANK; H_ON -> FAULT when blank_cnt == BLANK & desat_s.
REQ-021 desat_s SHALL be ignored in OFF, L_ON and during blanking.
REQ-022 If exit and fault conditions coincide in H_ON, FAULT SHALL take priority.
REQ-023 FAULT: gh=gl=0; FAULT -> OFF (dt_cnt=0) only when flt_clr & !k1_in & !k2_in in the same cycle; flt_clr SHALL be ignored otherwise.
REQ-024 An overlap event is a rising edge of (k1_in & k2_in); gh and gl SHALL never be 1 simultaneously under any input sequence.

Reset
REQ-025 rst SHALL force state=OFF, dt_cnt=0, blank_cnt=0, synchronizer flops=0, gh=gl=fault=0, ovl_cnt=0 on the next edge, overriding all other inputs including mid-pulse and FAULT.
REQ-026 After reset release, no gate SHALL rise until DEADTIME cycles have elapsed in OFF.

Configuration
REQ-027 Macro GATE_OVL_CNT_EN defined: ovl_cnt SHALL increment by 1 per overlap event, saturating at 255, cleared only by rst.
REQ-028 Macro GATE_OVL_CNT_EN undefined: ovl_cnt SHALL be constant 0 with no counter logic; all other behaviour is unchanged.

Verification
REQ-029 Reset, then k2_in=1 held -> gl rises on cycle 41 after rst deassert; gh stays 0.
REQ-030 In L_ON, switch k2_in 1->0 and k1_in 0->1 in the same cycle -> gl falls next cycle, gh rises exactly 41 cycles after gl fell.
REQ-031 In H_ON, desat=1 at cycle 10 after gh rise -> no fault; desat=1 held from cycle 90 -> fault=1 and gh=0 at cycle 93.
REQ-032 In FAULT, flt_clr=1 with k2_in=1 -> stays in FAULT; flt_clr=1 with both commands 0 -> fault=0 next cycle, gates low for a further 40 cycles.
REQ-033 k1_in=k2_in=1 for 5 cycles, repeated 3 times -> gh=gl=0 throughout; ovl_cnt=3 with GATE_OVL_CNT_EN defined, 0 without.
REQ-034 Assert rst mid-H_ON and mid-FAULT -> all outputs 0 next cycle; recovery as in REQ-029.
